playfield_scroll_gen: RTL and testbench
=======================================

// Module: playfield_scroll_gen
// PURPOSE
//  Parametrised successor to the static Frogger background generator: draws border, homes, walls,
//  yellow safe strips, water and street. Adds per-lane scrolling logs/cars, home-occupied state and
//  a hazard map for frog collision logic. Sits between vga_controller (x, y, video_on) and the VGA
//  port. Offsets advance once per frame.
// PARAMETERS
//  NUM_LANES    5          lanes per zone; water y=68..227, street y=260..419, 32 px per lane
//  NUM_HOMES    5          home slots at y=36..67, 64 px wide, separated by 64 px walls, from x=32
//  PERIOD_LOG2  7          object pattern period = 2**PERIOD_LOG2 px; must divide 640
//  SPEED_W      3          bits per lane speed (px/frame)
//  WATER_SPEED  15'h2A51   packed {lane4..lane0} speeds for the water zone, SPEED_W bits each
//  ROAD_SPEED   15'h1C8B   packed {lane4..lane0} speeds for the street zone
//  LOG_LEN      96         log length in px within each period (water); must be <= 2**PERIOD_LOG2
//  CAR_LEN      40         car length in px within each period (street); must be <= 2**PERIOD_LOG2
// PORTS
//  clk_100MHz   in   1              system clock
//  reset_n      in   1              asynchronous, active-low reset
//  video_on     in   1              active-video flag from vga_controller
//  x            in   10             pixel column from vga_controller
//  y            in   10             pixel row from vga_controller
//  frame_tick   in   1              one-cycle pulse per frame (start of vblank)
//  pause        in   1              holds all lane offsets while high
//  home_set     in   1              one-cycle pulse: mark home_idx occupied
//  home_idx     in   3              home index 0..NUM_HOMES-1; values >= NUM_HOMES are ignored
//  home_clear   in   1              one-cycle pulse: clear all home flags
//  rgb          out  12             pixel colour, registered
//  hazard       out  1              1 = pixel is car, water without log, wall or filled home
//  homes_full   out  1              all NUM_HOMES flags set, registered
// BEHAVIOUR
//  Reset (async assert, sync deassert internally):
//   - rgb = 12'h000, hazard = 0, homes_full = 0
//   - all lane offsets = 0, all home flags = 0, pipeline valid bits = 0
//  Pipeline (latency exactly 2 clocks from x/y/video_on to rgb/hazard):
//   - S1 registers: region code, lane index, home index, sx = (x + off[lane])[PERIOD_LOG2-1:0], video_on
//   - S2 registers: rgb and hazard
//  Regions and priority, as in the static generator:
//   - bottom green > top black > side green > upper green strip > yellow > home/wall > street > water
//  Colours:
//   - GREEN 12'h2A6, BLUE 12'hA21, YELLOW 12'h5FF, BLACK 12'h000
//   - LOG 12'h036, CAR 12'h00F, FROG 12'h0F0
//  Water lane: sx < LOG_LEN draws LOG with hazard=0; otherwise draws BLUE with hazard=1.
//  Street lane: sx < CAR_LEN draws CAR with hazard=1; otherwise draws BLACK with hazard=0.
//  Homes: an empty home draws BLUE with hazard=0; a filled home draws FROG with hazard=1.
//  Walls: GREEN with hazard=1. All other regions: hazard=0.
//  video_on low (delayed with the pipeline): rgb = BLACK, hazard = 0.
//  Offsets:
//   - Each lane has an offset of PERIOD_LOG2 bits that wraps naturally mod 2**PERIOD_LOG2.
//     Because the period divides 640, the pattern is seamless across the screen edge.
//   - Updated only on cycles where frame_tick=1 and pause=0.
//   - Even lanes: off -= speed (objects move right). Odd lanes: off += speed (objects move left).
//   - Speed 0 leaves the lane static.
//   - frame_tick and pause together: no update.
//  Home flags:
//   - home_set sets flag[home_idx] on the next edge; setting an already-set flag changes nothing.
//   - home_clear and home_set in the same cycle: clear wins, so all flags end at 0.
//   - homes_full updates the clock after the last flag is set.
//  Reset mid-frame: outputs drop to reset values immediately; drawing resumes at offset 0 with no stale pixels.
// STRUCTURE
//  frogger_pkg: colour constants, region-code enum, zone y bounds, border width (32), home and wall width (64).
//  Sub-module lane_scroller (params: PERIOD_LOG2, SPEED_W, SPEED, DIR):
//   - holds one offset register; inputs clk_100MHz, reset_n, advance; output off
//   - instantiated 2*NUM_LANES times via generate
//  Top level holds home flags, region decode, the S1/S2 pipeline and the output muxes.
// TESTING
//  1. Reset with video_on=1, x=100, y=10 -> after 2 clk: rgb=000, hazard=0; x=100, y=460 -> rgb=2A6.
//  2. Offsets 0, water lane 0 (y=70): x=50 -> rgb=036, hazard=0; x=100 -> rgb=A21, hazard=1.
//  3. Street lane 0 speed 3 (even lane): one frame_tick -> off=125; x=35 at y=262: sx=(35+125)&127=32 < 40 -> rgb=00F, hazard=1.
//  4. pause=1 with 10 frame_ticks -> all offsets unchanged; then 43 ticks at speed 3 -> lane 0 off=(0-129)&127=127 (wrap).
//  5. home_set idx 0..4 -> homes_full=1 one clk after 5th; x=40, y=40 -> rgb=0F0; home_set+home_clear same clk -> all flags 0.
//  6. Assert reset_n=0 mid-line with offsets nonzero -> rgb=000 asynchronously, offsets 0; home_idx=6 set pulse -> no flag change.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared colours, region codes and playfield geometry for the scrolling
// Frogger background generator.
package frogger_pkg;

  localparam logic [11:0] C_GREEN  = 12'h2A6;
  localparam logic [11:0] C_BLUE   = 12'hA21;
  localparam logic [11:0] C_YELLOW = 12'h5FF;
  localparam logic [11:0] C_BLACK  = 12'h000;
  localparam logic [11:0] C_LOG    = 12'h036;
  localparam logic [11:0] C_CAR    = 12'h00F;
  localparam logic [11:0] C_FROG   = 12'h0F0;

  typedef enum logic [2:0] {
    RG_BLACK,
    RG_GREEN,
    RG_YELLOW,
    RG_HOME,
    RG_WALL,
    RG_STREET,
    RG_WATER
  } region_t;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] BORDER_W = 10'd32;
  localparam logic [9:0] HOME_W   = 10'd64;
  localparam logic [9:0] Y_UPPER  = 10'd32;
  localparam logic [9:0] Y_HOME   = 10'd36;
  localparam logic [9:0] Y_WATER  = 10'd68;
  localparam logic [9:0] Y_YEL0   = 10'd228;
  localparam logic [9:0] Y_STREET = 10'd260;
  localparam logic [9:0] Y_YEL1   = 10'd420;
  localparam logic [9:0] Y_BOTTOM = 10'd452;
  localparam int         LANE_SH  = 5;
  localparam int         HOME_SH  = 6;

endpackage

// File: rtl/lane_scroller.sv
// One lane's horizontal scroll offset; wraps modulo the object pattern period.
module lane_scroller #(
  parameter int               PERIOD_LOG2 = 7,
  parameter int               SPEED_W     = 3,
  parameter logic [SPEED_W-1:0] SPEED     = '0,
  parameter bit               DIR         = 1'b0
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_n,
  input  logic                   advance,
  output logic [PERIOD_LOG2-1:0] off
);

  localparam logic [PERIOD_LOG2-1:0] STEP = PERIOD_LOG2'(SPEED);

  logic [PERIOD_LOG2-1:0] r_off;

  // DIR=0 decrements (objects drift right), DIR=1 increments (drift left)
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)     r_off <= '0;
    else if (advance) r_off <= DIR ? r_off + STEP : r_off - STEP;
  end

  assign off = r_off;

endmodule

// File: rtl/playfield_scroll_gen.sv
// Frogger playfield generator with scrolling logs/cars, home flags and a
// per-pixel hazard map; two-stage pipeline from (x, y, video_on) to rgb/hazard.
module playfield_scroll_gen
  import frogger_pkg::*;
#(
  parameter int NUM_LANES   = 5,
  parameter int NUM_HOMES   = 5,
  parameter int PERIOD_LOG2 = 7,
  parameter int SPEED_W     = 3,
  parameter logic [NUM_LANES*SPEED_W-1:0] WATER_SPEED = 15'h2A51,
  parameter logic [NUM_LANES*SPEED_W-1:0] ROAD_SPEED  = 15'h1C8B,
  parameter int LOG_LEN     = 96,
  parameter int CAR_LEN     = 40
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        home_set,
  input  logic [2:0]  home_idx,
  input  logic        home_clear,
  output logic [11:0] rgb,
  output logic        hazard,
  output logic        homes_full
);

  localparam logic [PERIOD_LOG2:0] LOG_LIM = (PERIOD_LOG2+1)'(LOG_LEN);
  localparam logic [PERIOD_LOG2:0] CAR_LIM = (PERIOD_LOG2+1)'(CAR_LEN);

  // Async assert, synchronous release of the internal reset
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic w_advance;
  logic [NUM_LANES-1:0][PERIOD_LOG2-1:0] w_off_water;
  logic [NUM_LANES-1:0][PERIOD_LOG2-1:0] w_off_street;

  assign w_advance = frame_tick & ~pause;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_scroller #(
      .PERIOD_LOG2 (PERIOD_LOG2),
      .SPEED_W     (SPEED_W),
      .SPEED       (WATER_SPEED[g*SPEED_W +: SPEED_W]),
      .DIR         ((g % 2) == 1)
    ) u_water (
      .clk_100MHz (clk_100MHz),
      .reset_n    (w_rst_n),
      .advance    (w_advance),
      .off        (w_off_water[g])
    );
    lane_scroller #(
      .PERIOD_LOG2 (PERIOD_LOG2),
      .SPEED_W     (SPEED_W),
      .SPEED       (ROAD_SPEED[g*SPEED_W +: SPEED_W]),
      .DIR         ((g % 2) == 1)
    ) u_street (
      .clk_100MHz (clk_100MHz),
      .reset_n    (w_rst_n),
      .advance    (w_advance),
      .off        (w_off_street[g])
    );
  end

  // Home flags; clear has priority over set
  logic [NUM_HOMES-1:0] r_home_flags;
  logic                 r_homes_full;

  always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_home_flags <= '0;
      r_homes_full <= 1'b0;
    end else begin
      if (home_clear)
        r_home_flags <= '0;
      else if (home_set && (home_idx < 3'(NUM_HOMES)))
        r_home_flags[home_idx] <= 1'b1;
      r_homes_full <= &r_home_flags;
    end
  end

  // Region decode, highest priority first
  region_t                w_region;
  logic [9:0]             w_hx;
  logic [3:0]             w_slot;
  logic [9:0]             w_dy;
  logic [2:0]             w_lane;
  logic [PERIOD_LOG2-1:0] w_off;
  logic [PERIOD_LOG2-1:0] w_sx;

  assign w_hx   = x - BORDER_W;
  assign w_slot = 4'(w_hx >> HOME_SH);

  always_comb begin
    w_region = RG_WATER;
    if (y >= Y_BOTTOM)                                   w_region = RG_GREEN;
    else if (y < Y_UPPER)                                w_region = RG_BLACK;
    else if (x < BORDER_W || x >= SCREEN_W - BORDER_W)   w_region = RG_GREEN;
    else if (y < Y_HOME)                                 w_region = RG_GREEN;
    else if ((y >= Y_YEL0 && y < Y_STREET) || y >= Y_YEL1) w_region = RG_YELLOW;
    else if (y < Y_WATER)
      w_region = (w_slot[0] || w_slot[3:1] >= 3'(NUM_HOMES)) ? RG_WALL : RG_HOME;
    else if (y >= Y_STREET)                              w_region = RG_STREET;
  end

  assign w_dy   = y - ((w_region == RG_STREET) ? Y_STREET : Y_WATER);
  assign w_lane = 3'(w_dy >> LANE_SH);
  assign w_off  = (w_region == RG_STREET) ? w_off_street[w_lane] : w_off_water[w_lane];
  assign w_sx   = x[PERIOD_LOG2-1:0] + w_off;

  // S1
  region_t                r_s1_region;
  logic [2:0]             r_s1_home;
  logic [PERIOD_LOG2-1:0] r_s1_sx;
  logic                   r_s1_von;

  always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_region <= RG_BLACK;
      r_s1_home   <= '0;
      r_s1_sx     <= '0;
      r_s1_von    <= 1'b0;
    end else begin
      r_s1_region <= w_region;
      r_s1_home   <= w_slot[3:1];
      r_s1_sx     <= w_sx;
      r_s1_von    <= video_on;
    end
  end

  // S2: colour and hazard
  logic [11:0] r_rgb;
  logic        r_hazard;

  always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rgb    <= C_BLACK;
      r_hazard <= 1'b0;
    end else begin
      r_rgb    <= C_BLACK;
      r_hazard <= 1'b0;
      if (r_s1_von) begin
        case (r_s1_region)
          RG_GREEN:  r_rgb <= C_GREEN;
          RG_YELLOW: r_rgb <= C_YELLOW;
          RG_WALL: begin
            r_rgb    <= C_GREEN;
            r_hazard <= 1'b1;
          end
          RG_HOME: begin
            r_rgb    <= r_home_flags[r_s1_home] ? C_FROG : C_BLUE;
            r_hazard <= r_home_flags[r_s1_home];
          end
          RG_STREET: begin
            if ({1'b0, r_s1_sx} < CAR_LIM) begin
              r_rgb    <= C_CAR;
              r_hazard <= 1'b1;
            end
          end
          RG_WATER: begin
            if ({1'b0, r_s1_sx} < LOG_LIM) begin
              r_rgb <= C_LOG;
            end else begin
              r_rgb    <= C_BLUE;
              r_hazard <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rgb        = r_rgb;
  assign hazard     = r_hazard;
  assign homes_full = r_homes_full;

endmodule

// File: tb/tb_playfield_scroll_gen.sv
// Scoreboard bench for playfield_scroll_gen: directed scenarios plus random
// pixel/frame traffic checked against a behavioural playfield model.
module tb_playfield_scroll_gen;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  logic        video_on   = 1'b0;
  logic [9:0]  x          = '0;
  logic [9:0]  y          = '0;
  logic        frame_tick = 1'b0;
  logic        pause      = 1'b0;
  logic        home_set   = 1'b0;
  logic [2:0]  home_idx   = '0;
  logic        home_clear = 1'b0;
  logic [11:0] rgb;
  logic        hazard;
  logic        homes_full;

  playfield_scroll_gen dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .pause      (pause),
    .home_set   (home_set),
    .home_idx   (home_idx),
    .home_clear (home_clear),
    .rgb        (rgb),
    .hazard     (hazard),
    .homes_full (homes_full)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hz;
    logic        full;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  int SPD_W[5] = '{1, 2, 1, 5, 2};
  int SPD_S[5] = '{3, 1, 2, 6, 1};
  int m_off_w[5];
  int m_off_s[5];
  bit m_flags[5];

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 5; i++) f &= m_flags[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_off_w[i] = 0;
      m_off_s[i] = 0;
      m_flags[i] = 1'b0;
    end
  endtask

  task automatic model_px(input int xx, input int yy, input bit von,
                          output logic [11:0] c, output bit hz);
    int slot, lane, sx;
    c  = 12'h000;
    hz = 1'b0;
    if (!von) return;
    if (yy >= 452)                              c = 12'h2A6;
    else if (yy < 32)                           c = 12'h000;
    else if (xx < 32 || xx >= 608)              c = 12'h2A6;
    else if (yy < 36)                           c = 12'h2A6;
    else if ((yy >= 228 && yy < 260) || yy >= 420) c = 12'h5FF;
    else if (yy < 68) begin
      slot = (xx - 32) / 64;
      if (slot % 2 == 1) begin c = 12'h2A6; hz = 1'b1; end
      else if (m_flags[slot / 2]) begin c = 12'h0F0; hz = 1'b1; end
      else c = 12'hA21;
    end else if (yy >= 260) begin
      lane = (yy - 260) / 32;
      sx   = (xx + m_off_s[lane]) % 128;
      if (sx < 40) begin c = 12'h00F; hz = 1'b1; end
    end else begin
      lane = (yy - 68) / 32;
      sx   = (xx + m_off_w[lane]) % 128;
      if (sx < 96) c = 12'h036;
      else begin c = 12'hA21; hz = 1'b1; end
    end
  endtask

  // Drive one cycle of inputs; optionally queue the expected response
  task automatic step(input int xx, input int yy, input bit von, input bit ft,
                      input bit ps, input bit hs, input int hi, input bit hc,
                      input bit chk, input bit use_c,
                      input logic [11:0] c_rgb, input bit c_hz);
    exp_t e;
    logic [11:0] mc;
    bit mh;
    @(posedge clk_100MHz);
    #2;
    x          = 10'(xx);
    y          = 10'(yy);
    video_on   = von;
    frame_tick = ft;
    pause      = ps;
    home_set   = hs;
    home_idx   = 3'(hi);
    home_clear = hc;
    if (hc) for (int i = 0; i < 5; i++) m_flags[i] = 1'b0;
    else if (hs && hi < 5) m_flags[hi] = 1'b1;
    if (chk) begin
      model_px(xx, yy, von, mc, mh);
      e.due  = cyc + 2;
      e.rgb  = use_c ? c_rgb : mc;
      e.hz   = use_c ? c_hz : mh;
      e.full = m_full();
      sb.push_back(e);
    end
    if (ft && !ps) begin
      for (int i = 0; i < 5; i++) begin
        if (i % 2 == 0) begin
          m_off_w[i] = (m_off_w[i] - SPD_W[i] + 128) % 128;
          m_off_s[i] = (m_off_s[i] - SPD_S[i] + 128) % 128;
        end else begin
          m_off_w[i] = (m_off_w[i] + SPD_W[i]) % 128;
          m_off_s[i] = (m_off_s[i] + SPD_S[i]) % 128;
        end
      end
    end
  endtask

  task automatic px(input int xx, input int yy);
    step(xx, yy, 1, 0, 0, 0, 0, 0, 1, 0, 12'h000, 0);
  endtask

  task automatic pxc(input int xx, input int yy, input logic [11:0] c, input bit hz);
    step(xx, yy, 1, 0, 0, 0, 0, 0, 1, 1, c, hz);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares the output whose turn it is on this cycle
  always @(negedge clk_100MHz) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL pixel_missed: entry due cycle %0d never compared", mon_e.due);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (rgb !== mon_e.rgb || hazard !== mon_e.hz || homes_full !== mon_e.full) begin
        errors++;
        $display("FAIL pixel@%0d: got rgb=%h hazard=%b full=%b, expected rgb=%h hazard=%b full=%b",
                 cyc, rgb, hazard, homes_full, mon_e.rgb, mon_e.hz, mon_e.full);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    video_on = 1'b1;
    x        = 10'd100;
    y        = 10'd10;
    repeat (3) @(posedge clk_100MHz);
    #2;
    chk("reset_rgb", 32'(rgb), 32'h000);
    chk("reset_hazard", 32'(hazard), 32'h0);
    chk("reset_full", 32'(homes_full), 32'h0);
    reset_n = 1'b1;
    repeat (3) idle();

    // Static regions with zero offsets
    pxc(100, 10, 12'h000, 0);
    pxc(100, 460, 12'h2A6, 0);
    pxc(50, 70, 12'h036, 0);
    pxc(100, 70, 12'hA21, 1);
    px(40, 40);
    px(100, 40);
    px(10, 100);
    px(300, 33);
    px(300, 240);
    px(300, 430);
    step(300, 300, 0, 0, 0, 0, 0, 0, 1, 1, 12'h000, 0);

    // One frame: street lane 0 offset 125
    step(200, 100, 1, 1, 0, 0, 0, 0, 1, 0, 12'h000, 0);
    pxc(35, 262, 12'h00F, 1);
    pxc(42, 262, 12'h00F, 1);
    pxc(43, 262, 12'h000, 0);

    // Paused ticks change nothing
    for (int i = 0; i < 10; i++)
      step($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, 0, 0, 1, 0, 12'h000, 0);
    pxc(35, 262, 12'h00F, 1);
    pxc(43, 262, 12'h000, 0);

    // 42 more ticks: street lane 0 wraps to 127, water lane 0 at 85
    for (int i = 0; i < 42; i++)
      step($urandom_range(32, 607), $urandom_range(68, 419), 1, 1, 0, 0, 0, 0, 1, 0, 12'h000, 0);
    pxc(33, 262, 12'h00F, 1);
    pxc(40, 262, 12'h00F, 1);
    pxc(41, 262, 12'h000, 0);
    pxc(138, 70, 12'h036, 0);
    pxc(139, 70, 12'hA21, 1);
    for (int l = 0; l < 5; l++) begin
      px(200, 70 + 32 * l);
      px(200, 262 + 32 * l);
    end

    // Fill all homes
    px(40, 40);
    for (int i = 0; i < 5; i++)
      step(40 + 128 * i, 50, 1, 0, 0, 1, i, 0, 1, 0, 12'h000, 0);
    pxc(40, 40, 12'h0F0, 1);
    pxc(100, 40, 12'h2A6, 1);
    // Set and clear together: clear wins
    step(40, 40, 1, 0, 0, 1, 2, 1, 1, 0, 12'h000, 0);
    pxc(40, 40, 12'hA21, 0);
    px(300, 40);

    // Refill, advance, then reset mid-line
    for (int i = 0; i < 5; i++)
      step(40 + 128 * i, 50, 1, 1, 0, 1, i, 0, 1, 0, 12'h000, 0);
    pxc(300, 460, 12'h2A6, 0);
    pxc(300, 460, 12'h2A6, 0);
    pxc(300, 460, 12'h2A6, 0);
    @(posedge clk_100MHz);
    #3;
    sb.delete();
    model_reset();
    reset_n = 1'b0;
    #1;
    chk("async_reset_rgb", 32'(rgb), 32'h000);
    chk("async_reset_hazard", 32'(hazard), 32'h0);
    chk("async_reset_full", 32'(homes_full), 32'h0);
    repeat (2) @(posedge clk_100MHz);
    #2;
    reset_n = 1'b1;
    repeat (3) idle();
    step(40, 40, 1, 0, 0, 1, 6, 0, 1, 0, 12'h000, 0);
    step(40, 40, 1, 0, 0, 1, 5, 0, 1, 0, 12'h000, 0);
    step(40, 40, 1, 0, 0, 1, 7, 0, 1, 0, 12'h000, 0);
    pxc(40, 40, 12'hA21, 0);
    pxc(50, 70, 12'h036, 0);
    pxc(100, 70, 12'hA21, 1);
    pxc(35, 262, 12'h00F, 1);
    pxc(45, 262, 12'h000, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(639), $urandom_range(479), ($urandom_range(9) != 0),
           ($urandom_range(19) == 0), ($urandom_range(3) == 0),
           ($urandom_range(29) == 0), $urandom_range(7),
           ($urandom_range(99) == 0), 1, 0, 12'h000, 0);

    repeat (3) idle();
    @(posedge clk_100MHz);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
